// File: rtl/control_multi.sv
// control_multi: Moore FSM controller for the multi-cycle MIPS datapath.
// Handles R-format, JR, LW, SW, ORI, BEQ and J. Sequences fetch, decode,
// execute, memory and writeback. Memory states wait on mem_ready, and a
// wait longer than WAIT_MAX cycles traps.
// The optional performance counters (cycle_cnt, instr_cnt) are enabled by
// defining MC_PERF_CNT_EN.
module control_multi #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic [3:0]       state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_ORI = 6'd13;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;
  localparam logic [5:0] FN_JR  = 6'd8;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REXE, S_RWB, S_OEXE, S_OWB, S_BR, S_JMP, S_JR, S_TRAP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctl_t;

  state_t     state_q, state_d;
  ctl_t       ctl_q, ctl_d;
  logic [7:0] wait_cnt;
  logic       timeout;
  logic       wait_state;

  // The datapath qualifies PCWriteCond with zero itself; the controller only
  // carries the flag through for interface completeness.
  logic unused_ok;
  assign unused_ok = zero;

  assign timeout    = (wait_cnt == 8'(WAIT_MAX)) && !mem_ready;
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR);

  // Next-state logic: dispatch on opcode in DECODE, stall memory states on mem_ready.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
                else if (timeout) state_d = S_TRAP;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW)  state_d = S_MEMADR;
        else if (opcode == OP_R)                 state_d = (funct == FN_JR) ? S_JR : S_REXE;
        else if (opcode == OP_ORI)               state_d = S_OEXE;
        else if (opcode == OP_BEQ)               state_d = S_BR;
        else if (opcode == OP_J)                 state_d = S_JMP;
        else                                     state_d = S_TRAP;
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
                else if (timeout) state_d = S_TRAP;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
                else if (timeout) state_d = S_TRAP;
      S_REXE:   state_d = S_RWB;
      S_OEXE:   state_d = S_OWB;
      S_MEMWB, S_RWB, S_OWB, S_BR, S_JMP, S_JR: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // Output decode of the upcoming state, so the outputs can be registered
  // and still line up with the state they belong to.
  always_comb begin
    ctl_d = '0;
    unique case (state_d)
      S_FETCH:  begin ctl_d.mem_read = 1'b1; ctl_d.alu_src_b = 2'b01; end
      S_DECODE: ctl_d.alu_src_b = 2'b11;
      S_MEMADR: begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_src_b = 2'b10; end
      S_MEMRD:  begin ctl_d.mem_read = 1'b1; ctl_d.iord = 1'b1; end
      S_MEMWB:  begin ctl_d.reg_write = 1'b1; ctl_d.mem_to_reg = 1'b1; end
      S_MEMWR:  begin ctl_d.mem_write = 1'b1; ctl_d.iord = 1'b1; end
      S_REXE:   begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_op = 2'b10; end
      S_RWB:    begin ctl_d.reg_write = 1'b1; ctl_d.reg_dst = 1'b1; end
      S_OEXE:   begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_src_b = 2'b10;
                      ctl_d.alu_op = 2'b11; end
      S_OWB:    ctl_d.reg_write = 1'b1;
      S_BR:     begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_op = 2'b01;
                      ctl_d.pc_write_cond = 1'b1; ctl_d.pc_source = 2'b01; end
      S_JMP:    begin ctl_d.pc_write = 1'b1; ctl_d.pc_source = 2'b10; end
      S_JR:     begin ctl_d.pc_write = 1'b1; ctl_d.pc_source = 2'b11; end
      S_TRAP:   ctl_d.illegal = 1'b1;
      default:  ctl_d = '0;
    endcase
  end

  // State, wait counter and registered outputs; reset aborts any access at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_START;
      wait_cnt <= '0;
      ctl_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      ctl_q    <= ctl_d;
      // Counts only while stalled in a memory state; any state change clears it.
      wait_cnt <= (wait_state && state_d == state_q) ? wait_cnt + 8'd1 : 8'd0;
    end
  end

  // Fetch completes in the same cycle mem_ready arrives, so PC and IR loads
  // follow the handshake directly.
  assign PCWrite     = ctl_q.pc_write | ((state_q == S_FETCH) & mem_ready);
  assign IRWrite     = (state_q == S_FETCH) & mem_ready;
  assign PCWriteCond = ctl_q.pc_write_cond;
  assign IorD        = ctl_q.iord;
  assign MemRead     = ctl_q.mem_read;
  assign MemWrite    = ctl_q.mem_write;
  assign MemtoReg    = ctl_q.mem_to_reg;
  assign RegDst      = ctl_q.reg_dst;
  assign RegWrite    = ctl_q.reg_write;
  assign ALUSrcA     = ctl_q.alu_src_a;
  assign ALUSrcB     = ctl_q.alu_src_b;
  assign ALUOp       = ctl_q.alu_op;
  assign PCSource    = ctl_q.pc_source;
  assign illegal     = ctl_q.illegal;
  assign state       = state_q;

`ifdef MC_PERF_CNT_EN
  logic terminal;
  assign terminal = (state_q == S_MEMWB) || (state_q == S_MEMWR) || (state_q == S_RWB) ||
                    (state_q == S_OWB) || (state_q == S_BR) || (state_q == S_JMP) ||
                    (state_q == S_JR);

  // Cycle count while running; instruction count on each retire back into FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state_q != S_START && state_q != S_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (terminal && state_d == S_FETCH)          instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_control_multi.sv
// tb_control_multi: directed bench for control_multi (WAIT_MAX=3).
// Counter checks are compiled in when MC_PERF_CNT_EN is defined.
module tb_control_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic illegal;
  logic [3:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int tests = 0;
  int fails = 0;

  control_multi #(.WAIT_MAX(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .illegal(illegal),
    .state(state)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
  //  ALUSrcB,ALUOp,PCSource,illegal}
  logic [16:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};

  localparam logic [3:0] S_START = 4'd0,  S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                         S_MEMRD = 4'd4,  S_MEMWB = 4'd5, S_MEMWR = 4'd6,  S_REXE = 4'd7,
                         S_RWB = 4'd8,    S_OEXE = 4'd9,  S_OWB = 4'd10,   S_BR = 4'd11,
                         S_JMP = 4'd12,   S_JR = 4'd13,   S_TRAP = 4'd14;

  localparam logic [16:0] C_IDLE      = 17'd0;
  localparam logic [16:0] C_FETCH_RDY = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] C_FETCH_WT  = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] C_DECODE    = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] C_MEMADR    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] C_MEMRD     = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] C_MEMWB     = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] C_MEMWR     = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] C_REXE      = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] C_RWB       = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] C_OEXE      = {10'b0000000001, 2'b10, 2'b11, 2'b00, 1'b0};
  localparam logic [16:0] C_OWB       = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] C_BR        = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [16:0] C_JMP       = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [16:0] C_JR        = {10'b1000000000, 2'b00, 2'b00, 2'b11, 1'b0};
  localparam logic [16:0] C_TRAP      = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset between edges; the DUT then sits in START until the next edge.
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd35;
    #1;
    tests++;
    if (state !== S_START || ctl !== C_IDLE) begin
      fails++;
      $display("FAIL reset_async: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_START, C_IDLE);
    end
    tick();
    tests++;
    if (state !== S_START || ctl !== C_IDLE) begin
      fails++;
      $display("FAIL reset_held: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_START, C_IDLE);
    end
  endtask

  task automatic test_rtype();
    logic [3:0]  es[5] = '{S_FETCH, S_DECODE, S_REXE, S_RWB, S_FETCH};
    logic [16:0] ec[5] = '{C_FETCH_RDY, C_DECODE, C_REXE, C_RWB, C_FETCH_RDY};
    opcode = 6'd0; funct = 6'h20; mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (state !== S_START || ctl !== C_IDLE) begin
      fails++;
      $display("FAIL rtype_start: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_START, C_IDLE);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (state !== es[i] || ctl !== ec[i]) begin
        fails++;
        $display("FAIL rtype_step%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state, ctl, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_fetch_wait();
    mem_ready = 1'b0;
    #1;
    tests++;
    if (state !== S_FETCH || ctl !== C_FETCH_WT) begin
      fails++;
      $display("FAIL fetch_wait_now: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_FETCH, C_FETCH_WT);
    end
    tick();
    tests++;
    if (state !== S_FETCH || ctl !== C_FETCH_WT) begin
      fails++;
      $display("FAIL fetch_wait_held: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_FETCH, C_FETCH_WT);
    end
    mem_ready = 1'b1;
    #1;
    tests++;
    if (ctl !== C_FETCH_RDY) begin
      fails++;
      $display("FAIL fetch_ready: ctl=%b, expected ctl=%b", ctl, C_FETCH_RDY);
    end
  endtask

  task automatic test_lw();
    opcode = 6'd35; mem_ready = 1'b1;
    tick();
    tests++;
    if (state !== S_DECODE || ctl !== C_DECODE) begin
      fails++;
      $display("FAIL lw_decode: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_DECODE, C_DECODE);
    end
    tick();
    tests++;
    if (state !== S_MEMADR || ctl !== C_MEMADR) begin
      fails++;
      $display("FAIL lw_memadr: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_MEMADR, C_MEMADR);
    end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      tests++;
      if (state !== S_MEMRD || ctl !== C_MEMRD) begin
        fails++;
        $display("FAIL lw_memrd_cycle%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i + 1, state, ctl, S_MEMRD, C_MEMRD);
      end
      tick();
    end
    tests++;
    if (state !== S_MEMWB || ctl !== C_MEMWB) begin
      fails++;
      $display("FAIL lw_memwb: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_MEMWB, C_MEMWB);
    end
    tick();
    tests++;
    if (state !== S_FETCH || ctl !== C_FETCH_RDY) begin
      fails++;
      $display("FAIL lw_refetch: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_FETCH, C_FETCH_RDY);
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0]  ops[5] = '{6'd4, 6'd4, 6'd0, 6'd2, 6'd13};
    logic [5:0]  fns[5] = '{6'h00, 6'h00, 6'd8, 6'h00, 6'h00};
    logic        zs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0]  es[5]  = '{S_BR, S_BR, S_JR, S_JMP, S_OEXE};
    logic [16:0] ec[5]  = '{C_BR, C_BR, C_JR, C_JMP, C_OEXE};
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k]; funct = fns[k]; zero = zs[k];
      tick();
      tick();
      tests++;
      if (state !== es[k] || ctl !== ec[k]) begin
        fails++;
        $display("FAIL exec_op%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 ops[k], state, ctl, es[k], ec[k]);
      end
      tick();
      if (k == 4) begin
        tests++;
        if (state !== S_OWB || ctl !== C_OWB) begin
          fails++;
          $display("FAIL ori_owb: state=%0d ctl=%b, expected state=%0d ctl=%b",
                   state, ctl, S_OWB, C_OWB);
        end
        tick();
      end
      tests++;
      if (state !== S_FETCH) begin
        fails++;
        $display("FAIL return_op%0d: state=%0d, expected state=%0d", ops[k], state, S_FETCH);
      end
    end
  endtask

  task automatic test_trap();
    opcode = 6'd63; funct = 6'd0;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      tests++;
      if (state !== S_TRAP || ctl !== C_TRAP) begin
        fails++;
        $display("FAIL trap_cycle%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 i, state, ctl, S_TRAP, C_TRAP);
      end
      tick();
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (state !== S_START || ctl !== C_IDLE) begin
      fails++;
      $display("FAIL trap_reset: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_START, C_IDLE);
    end
  endtask

  task automatic test_sw_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      opcode = 6'd43; mem_ready = 1'b1;
      release_reset();
      tick();
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
        if (pass == 1 && i == 3) mem_ready = 1'b1;
        tests++;
        if (state !== S_MEMWR || ctl !== C_MEMWR) begin
          fails++;
          $display("FAIL sw_pass%0d_memwr%0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                   pass, i + 1, state, ctl, S_MEMWR, C_MEMWR);
        end
        tick();
      end
      tests++;
      if (pass == 0 && (state !== S_TRAP || ctl !== C_TRAP)) begin
        fails++;
        $display("FAIL sw_timeout: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 state, ctl, S_TRAP, C_TRAP);
      end else if (pass == 1 && (state !== S_FETCH || ctl !== C_FETCH_RDY)) begin
        fails++;
        $display("FAIL sw_last_cycle: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 state, ctl, S_FETCH, C_FETCH_RDY);
      end
    end
  endtask

  task automatic test_abort();
    opcode = 6'd35; mem_ready = 1'b1;
    release_reset();
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    tests++;
    if (state !== S_MEMRD || MemRead !== 1'b1) begin
      fails++;
      $display("FAIL abort_setup: state=%0d MemRead=%b, expected state=%0d MemRead=1",
               state, MemRead, S_MEMRD);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (state !== S_START || ctl !== C_IDLE) begin
      fails++;
      $display("FAIL abort_now: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_START, C_IDLE);
    end
    mem_ready = 1'b1;
    tick();
    tests++;
    if (state !== S_START || ctl !== C_IDLE) begin
      fails++;
      $display("FAIL abort_held: state=%0d ctl=%b, expected state=%0d ctl=%b",
               state, ctl, S_START, C_IDLE);
    end
  endtask

`ifdef MC_PERF_CNT_EN
  task automatic test_perf();
    opcode = 6'd0; funct = 6'h20; mem_ready = 1'b1;
    release_reset();
    tick();
    tests++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      fails++;
      $display("FAIL perf_start: cycle=%0d instr=%0d, expected cycle=0 instr=0",
               cycle_cnt, instr_cnt);
    end
    repeat (4) tick();
    opcode = 6'd35;
    repeat (5) tick();
    opcode = 6'd2;
    repeat (3) tick();
    tests++;
    if (state !== S_FETCH || cycle_cnt !== 32'd12 || instr_cnt !== 32'd3) begin
      fails++;
      $display("FAIL perf_counts: state=%0d cycle=%0d instr=%0d, expected state=%0d cycle=12 instr=3",
               state, cycle_cnt, instr_cnt, S_FETCH);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_fetch_wait();
    test_lw();
    test_branch_jump();
    test_trap();
    test_sw_timeout();
    test_abort();
`ifdef MC_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
